hazard_ctrl_dc: RTL and testbench
=================================

// Module: hazard_ctrl_dc
// PURPOSE
//  Stall/flush sequencer for the decode stage of the 3-stage pipeline. Holds a
//  busy-bit scoreboard of registers with outstanding long-latency writes (load,
//  mul/div), stalls decode on RAW/WAW hazards and drives flush_s3 on redirects.
//  Sits beside decode_dp; its flush_s3_o feeds decode_dp flush_s3_i.
// PARAMETERS
//  FLUSH_CYCLES   1   cycles flush_s3_o stays high per redirect (>=1)
//  STALL_TIMEOUT  64  consecutive stall cycles before timeout_o sets (>=2)
//  CNT_W          32  width of the stall performance counter
// PORTS
//  clk_i            in   1      clock, rising edge
//  rst_ni           in   1      reset, asynchronous, active-low
//  instr_valid_dc_i in   1      decode holds a valid instruction
//  rs1_a_dc_i       in   5      reg_e, source 1 address
//  rs1_used_dc_i    in   1      instruction reads rs1
//  rs2_a_dc_i       in   5      reg_e, source 2 address
//  rs2_used_dc_i    in   1      instruction reads rs2
//  rd_a_dc_i        in   5      reg_e, destination address
//  rd_long_dc_i     in   1      instruction is a long-latency writer of rd
//  wb_valid_i       in   1      a long-latency result is written back this cycle
//  wb_rd_a_i        in   5      reg_e, destination of that write-back
//  redirect_i       in   1      taken branch/jump resolved in execute
//  issue_dc_o       out  1      decode instruction leaves decode this cycle
//  stall_dc_o       out  1      hold PC, fetch and decode registers
//  flush_s3_o       out  1      squash the decode->execute registers
//  busy_o           out  32     scoreboard view, bit n = xn pending
//  stall_cnt_o      out  CNT_W  total stall cycles, saturating
//  timeout_o        out  1      sticky: stall exceeded STALL_TIMEOUT
// BEHAVIOUR
//  Reset (rst_ni=0, async): busy=0, state=RUN, stall counters=0, timeout_o=0.
//   All comb outputs=0 while inputs are idle.
//  hazard = instr_valid & ((rs1_used & busy[rs1]) | (rs2_used & busy[rs2]) |
//   (rd_long & busy[rd])). Uses registered busy only. No same-cycle write-back
//   bypass: a stall releases the cycle after wb_valid_i clears the bit.
//  x0 is never busy: set requests to x0 are ignored; busy_o[0] is always 0.
//  Priority per cycle: redirect > FLUSH state > hazard > issue.
//  FSM (hazard_state_e):
//   RUN:   redirect -> FLUSH (FLUSH_CYCLES>1) or stay RUN; hazard -> STALL
//   STALL: redirect -> FLUSH/RUN as above (stalled instr dropped);
//          hazard cleared -> RUN
//   FLUSH: flush count reaches FLUSH_CYCLES-1 -> RUN; redirect restarts count
//  flush_s3_o  = redirect_i | (state==FLUSH). Combinational, same cycle.
//  stall_dc_o  = hazard & !flush_s3_o.
//  issue_dc_o  = instr_valid & !hazard & !flush_s3_o.
//  On issue with rd_long=1 and rd!=0: busy[rd] set at the next edge.
//  wb_valid_i clears busy[wb_rd] at the next edge. A write-back to a non-busy
//   register is ignored. Set and clear of the same register in one cycle:
//   set wins.
//  Redirect never clears busy bits: the outstanding ops are older than the
//   branch and still complete.
//  stall_cnt_o +1 on every cycle with stall_dc_o=1; saturates at all-ones.
//  A consecutive-stall counter resets on any non-stall cycle. When it reaches
//   STALL_TIMEOUT, timeout_o sets and stays set until reset. The stall itself
//   continues.
//  Reset mid-stall or mid-flush returns to RUN with an empty scoreboard within
//   the same cycle.
// STRUCTURE
//  definitions_pkg: add hazard_state_e {HZ_RUN, HZ_STALL, HZ_FLUSH} and
//   SCOREBOARD_W=32. Reuse reg_e and REG_ZERO.
//  Sub-module reg_scoreboard: busy vector with set/clear ports, set-wins rule,
//   x0 hard-wired to 0, async active-low reset.
//  The FSM, hazard compare and counters stay in hazard_ctrl_dc.
// TESTING
//  1 Issue load rd=x5 (rd_long). Next instr reads rs1=x5; wb x5 arrives 3 cycles
//    later -> stall_dc_o=1 for 3 cycles, issue in the cycle after wb,
//    stall_cnt_o=3.
//  2 rs1=x0 with busy attempt on x0, and rd_long to x0 -> no stall,
//    busy_o stays 0.
//  3 Stalled on x7 and redirect_i pulses -> same cycle flush_s3_o=1,
//    stall_dc_o=0, issue_dc_o=0; busy[7] still 1 until wb.
//  4 FLUSH_CYCLES=3, redirect in one cycle -> flush_s3_o high 3 cycles. A second
//    redirect in cycle 2 extends the flush to cycle 4.
//  5 Issue rd_long to x9 in the same cycle as wb to x9 (not busy) ->
//    busy[9]=1 afterwards. Later WAW on x9 -> stall.
//  6 Hold hazard 70 cycles with STALL_TIMEOUT=64 -> timeout_o rises on the 64th
//    stall cycle and stays set. rst_ni low mid-stall -> busy_o=0, timeout_o=0,
//    stall_dc_o=0.

Source files
------------

// File: rtl/definitions_pkg.sv
// Shared pipeline definitions: register names, scoreboard width and decode hazard FSM states.
package definitions_pkg;

    typedef enum logic [4:0] {
        X0,  X1,  X2,  X3,  X4,  X5,  X6,  X7,
        X8,  X9,  X10, X11, X12, X13, X14, X15,
        X16, X17, X18, X19, X20, X21, X22, X23,
        X24, X25, X26, X27, X28, X29, X30, X31
    } reg_e;

    localparam reg_e REG_ZERO = X0;

    localparam int unsigned SCOREBOARD_W = 32;

    typedef enum logic [1:0] {
        HZ_RUN,
        HZ_STALL,
        HZ_FLUSH
    } hazard_state_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard of registers with an outstanding long-latency write.
// Set beats clear on the same register; x0 can never become busy.
module reg_scoreboard
    import definitions_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    set_i,
    input  logic [4:0]              set_a_i,
    input  logic                    clr_i,
    input  logic [4:0]              clr_a_i,
    output logic [SCOREBOARD_W-1:0] busy_o
);

    logic [SCOREBOARD_W-1:0] busy_q;
    logic [SCOREBOARD_W-1:0] busy_d;

    // Clear first so a simultaneous set on the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_i) begin
            busy_d[clr_a_i] = 1'b0;
        end
        if (set_i) begin
            busy_d[set_a_i] = 1'b1;
        end
        busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/hazard_ctrl_dc.sv
// Decode-stage stall/flush sequencer: RAW/WAW hazard detection against the busy
// scoreboard, redirect flush sequencing, stall statistics and a sticky stall timeout.
module hazard_ctrl_dc
    import definitions_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES  = 1,
    parameter int unsigned STALL_TIMEOUT = 64,
    parameter int unsigned CNT_W         = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    instr_valid_dc_i,
    input  logic [4:0]              rs1_a_dc_i,
    input  logic                    rs1_used_dc_i,
    input  logic [4:0]              rs2_a_dc_i,
    input  logic                    rs2_used_dc_i,
    input  logic [4:0]              rd_a_dc_i,
    input  logic                    rd_long_dc_i,
    input  logic                    wb_valid_i,
    input  logic [4:0]              wb_rd_a_i,
    input  logic                    redirect_i,
    output logic                    issue_dc_o,
    output logic                    stall_dc_o,
    output logic                    flush_s3_o,
    output logic [SCOREBOARD_W-1:0] busy_o,
    output logic [CNT_W-1:0]        stall_cnt_o,
    output logic                    timeout_o
);

    localparam int unsigned FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int unsigned TCNT_W = $clog2(STALL_TIMEOUT + 1);

    hazard_state_e           state_q;
    hazard_state_e           state_d;
    logic [FCNT_W-1:0]       fcnt_q;
    logic [FCNT_W-1:0]       fcnt_d;
    logic [CNT_W-1:0]        stall_cnt_q;
    logic [CNT_W-1:0]        stall_cnt_d;
    logic [TCNT_W-1:0]       consec_q;
    logic [TCNT_W-1:0]       consec_d;
    logic                    timeout_q;
    logic                    timeout_d;
    logic [SCOREBOARD_W-1:0] busy;
    logic                    hazard_c;
    logic                    flush_c;
    logic                    stall_c;
    logic                    issue_c;
    logic                    sb_set_c;

    reg_scoreboard u_scoreboard (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .set_i   (sb_set_c),
        .set_a_i (rd_a_dc_i),
        .clr_i   (wb_valid_i),
        .clr_a_i (wb_rd_a_i),
        .busy_o  (busy)
    );

    // Registered busy only: a write-back releases the stall one cycle later.
    assign hazard_c = instr_valid_dc_i &
                      ((rs1_used_dc_i & busy[rs1_a_dc_i]) |
                       (rs2_used_dc_i & busy[rs2_a_dc_i]) |
                       (rd_long_dc_i  & busy[rd_a_dc_i]));

    assign flush_c  = redirect_i | (state_q == HZ_FLUSH);
    assign stall_c  = hazard_c & ~flush_c;
    assign issue_c  = instr_valid_dc_i & ~hazard_c & ~flush_c;
    assign sb_set_c = issue_c & rd_long_dc_i & (rd_a_dc_i != REG_ZERO);

    // Redirect owns the cycle and (re)starts the flush window.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        if (redirect_i) begin
            if (FLUSH_CYCLES > 1) begin
                state_d = HZ_FLUSH;
                fcnt_d  = FCNT_W'(1);
            end else begin
                state_d = HZ_RUN;
                fcnt_d  = '0;
            end
        end else begin
            case (state_q)
                HZ_FLUSH: begin
                    if (fcnt_q == FCNT_W'(FLUSH_CYCLES - 1)) begin
                        state_d = HZ_RUN;
                        fcnt_d  = '0;
                    end else begin
                        fcnt_d  = fcnt_q + FCNT_W'(1);
                    end
                end
                default: begin
                    state_d = hazard_c ? HZ_STALL : HZ_RUN;
                end
            endcase
        end
    end

    // Stall statistics: saturating total plus consecutive run for the timeout.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        consec_d    = '0;
        timeout_d   = timeout_q;
        if (stall_c) begin
            if (stall_cnt_q != '1) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            consec_d = (consec_q == TCNT_W'(STALL_TIMEOUT)) ? consec_q : consec_q + TCNT_W'(1);
            if (consec_q == TCNT_W'(STALL_TIMEOUT - 1)) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= HZ_RUN;
            fcnt_q      <= '0;
            stall_cnt_q <= '0;
            consec_q    <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            stall_cnt_q <= stall_cnt_d;
            consec_q    <= consec_d;
            timeout_q   <= timeout_d;
        end
    end

    assign issue_dc_o  = issue_c;
    assign stall_dc_o  = stall_c;
    assign flush_s3_o  = flush_c;
    assign busy_o      = busy;
    assign stall_cnt_o = stall_cnt_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_hazard_ctrl_dc.sv
// Bench for hazard_ctrl_dc: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the scoreboard and flush window.
module tb_hazard_ctrl_dc;

    localparam int FC  = 3;
    localparam int TO  = 64;
    localparam int CW  = 8;
    localparam int SAT = 255;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, e1, e2, lng, wbv, redir;
    logic [4:0]  a1, a2, rd, wa;
    logic        issue_o, stall_o, flush_o, timeout_o;
    logic [31:0] busy_o;
    logic [CW-1:0] cnt_o;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    bit [31:0] m_busy;
    int        m_flush_left;
    int        m_total;
    int        m_consec;
    bit        m_timeout;
    bit        m_hz, m_flush, m_stall, m_issue;

    always #5 clk = ~clk;

    hazard_ctrl_dc #(
        .FLUSH_CYCLES (FC),
        .STALL_TIMEOUT(TO),
        .CNT_W        (CW)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .instr_valid_dc_i(valid),
        .rs1_a_dc_i      (a1),
        .rs1_used_dc_i   (e1),
        .rs2_a_dc_i      (a2),
        .rs2_used_dc_i   (e2),
        .rd_a_dc_i       (rd),
        .rd_long_dc_i    (lng),
        .wb_valid_i      (wbv),
        .wb_rd_a_i       (wa),
        .redirect_i      (redir),
        .issue_dc_o      (issue_o),
        .stall_dc_o      (stall_o),
        .flush_s3_o      (flush_o),
        .busy_o          (busy_o),
        .stall_cnt_o     (cnt_o),
        .timeout_o       (timeout_o)
    );

    task automatic model_comb();
        m_hz    = valid && ((e1 && m_busy[a1]) || (e2 && m_busy[a2]) || (lng && m_busy[rd]));
        m_flush = redir || (m_flush_left > 0);
        m_stall = m_hz && !m_flush;
        m_issue = valid && !m_hz && !m_flush;
    endtask

    task automatic model_update();
        model_comb();
        if (redir) m_flush_left = FC - 1;
        else if (m_flush_left > 0) m_flush_left = m_flush_left - 1;
        if (wbv) m_busy[wa] = 1'b0;
        if (m_issue && lng && rd != 5'd0) m_busy[rd] = 1'b1;
        if (m_stall) begin
            m_total  = (m_total < SAT) ? m_total + 1 : SAT;
            m_consec = m_consec + 1;
            if (m_consec >= TO) m_timeout = 1'b1;
        end else begin
            m_consec = 0;
        end
    endtask

    task automatic model_reset();
        m_busy = '0; m_flush_left = 0; m_total = 0; m_consec = 0; m_timeout = 1'b0;
    endtask

    // Drive inputs at posedge+1, settle to posedge+2.
    task automatic set_in(input bit v, input logic [4:0] s1, input bit u1,
                          input logic [4:0] s2, input bit u2, input logic [4:0] d,
                          input bit l, input bit w, input logic [4:0] wr, input bit r);
        valid = v; a1 = s1; e1 = u1; a2 = s2; e2 = u2; rd = d; lng = l;
        wbv = w; wa = wr; redir = r;
        #1;
        model_comb();
    endtask

    task automatic cyc();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        valid = 0; a1 = 0; e1 = 0; a2 = 0; e2 = 0; rd = 0; lng = 0; wbv = 0; wa = 0; redir = 0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if ({issue_o, stall_o, flush_o} !== 3'b000) begin errors++; $display("FAIL reset_comb: got %b exp 000", {issue_o, stall_o, flush_o}); end
        checks++; if (busy_o !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h exp 0", busy_o); end
        checks++; if (cnt_o !== '0 || timeout_o !== 1'b0) begin errors++; $display("FAIL reset_cnt: got cnt %0d to %b exp 0 0", cnt_o, timeout_o); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_in(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
        checks++; if (issue_o !== 1'b1) begin errors++; $display("FAIL lu_load_issue: got %b exp 1", issue_o); end
        cyc();
        checks++; if (busy_o !== 32'h20) begin errors++; $display("FAIL lu_busy5: got %h exp 00000020", busy_o); end
        for (int i = 0; i < 3; i++) begin
            set_in(1, 5, 1, 0, 0, 6, 0, (i == 2), 5, 0);
            checks++; if (stall_o !== 1'b1 || issue_o !== 1'b0) begin errors++; $display("FAIL lu_stall c%0d: got stall %b issue %b exp 1 0", i, stall_o, issue_o); end
            cyc();
        end
        set_in(1, 5, 1, 0, 0, 6, 0, 0, 0, 0);
        checks++; if (issue_o !== 1'b1 || stall_o !== 1'b0) begin errors++; $display("FAIL lu_release: got issue %b stall %b exp 1 0", issue_o, stall_o); end
        checks++; if (cnt_o !== 8'd3) begin errors++; $display("FAIL lu_stall_cnt: got %0d exp 3", cnt_o); end
        checks++; if (busy_o !== 32'h0) begin errors++; $display("FAIL lu_busy_clr: got %h exp 0", busy_o); end
        cyc();
    endtask

    task automatic test_x0();
        do_reset();
        set_in(1, 0, 1, 0, 0, 0, 1, 0, 0, 0);
        checks++; if (issue_o !== 1'b1 || stall_o !== 1'b0) begin errors++; $display("FAIL x0_issue1: got issue %b stall %b exp 1 0", issue_o, stall_o); end
        cyc();
        set_in(1, 0, 1, 0, 1, 0, 1, 0, 0, 0);
        checks++; if (issue_o !== 1'b1 || stall_o !== 1'b0) begin errors++; $display("FAIL x0_issue2: got issue %b stall %b exp 1 0", issue_o, stall_o); end
        cyc();
        checks++; if (busy_o !== 32'h0) begin errors++; $display("FAIL x0_busy: got %h exp 0", busy_o); end
    endtask

    task automatic test_redirect_stall();
        do_reset();
        set_in(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
        cyc();
        set_in(1, 0, 0, 7, 1, 8, 0, 0, 0, 0);
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL rs_stall: got %b exp 1", stall_o); end
        cyc();
        set_in(1, 0, 0, 7, 1, 8, 0, 0, 0, 1);
        checks++; if ({flush_o, stall_o, issue_o} !== 3'b100) begin errors++; $display("FAIL rs_redirect: got f/s/i %b exp 100", {flush_o, stall_o, issue_o}); end
        cyc();
        checks++; if (busy_o[7] !== 1'b1) begin errors++; $display("FAIL rs_busy_kept: got %b exp 1", busy_o[7]); end
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, (i == 2), 7, 0);
            checks++; if (flush_o !== (i < 2)) begin errors++; $display("FAIL rs_flush_tail c%0d: got %b exp %b", i, flush_o, (i < 2)); end
            cyc();
        end
        checks++; if (busy_o !== 32'h0) begin errors++; $display("FAIL rs_busy_wb: got %h exp 0", busy_o); end
    endtask

    task automatic test_flush_extend();
        do_reset();
        for (int c = 1; c <= 5; c++) begin
            set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, (c <= 2));
            checks++; if (flush_o !== (c <= 4) || issue_o !== (c == 5)) begin errors++; $display("FAIL fx_cycle%0d: got flush %b issue %b exp %b %b", c, flush_o, issue_o, (c <= 4), (c == 5)); end
            cyc();
        end
    endtask

    task automatic test_set_clear();
        do_reset();
        set_in(1, 0, 0, 0, 0, 9, 1, 1, 9, 0);
        checks++; if (issue_o !== 1'b1) begin errors++; $display("FAIL sc_issue: got %b exp 1", issue_o); end
        cyc();
        checks++; if (busy_o !== 32'h200) begin errors++; $display("FAIL sc_set_wins: got %h exp 00000200", busy_o); end
        set_in(1, 0, 0, 0, 0, 9, 1, 1, 10, 0);
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL sc_waw: got %b exp 1", stall_o); end
        cyc();
        checks++; if (busy_o !== 32'h200) begin errors++; $display("FAIL sc_wb_nonbusy: got %h exp 00000200", busy_o); end
        set_in(1, 0, 0, 0, 0, 9, 1, 1, 9, 0);
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL sc_no_bypass: got %b exp 1", stall_o); end
        cyc();
        set_in(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
        checks++; if (issue_o !== 1'b1) begin errors++; $display("FAIL sc_waw_release: got %b exp 1", issue_o); end
        cyc();
        checks++; if (busy_o !== 32'h200) begin errors++; $display("FAIL sc_reset_bit: got %h exp 00000200", busy_o); end
    endtask

    task automatic test_timeout();
        do_reset();
        set_in(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
        cyc();
        for (int i = 0; i < 40; i++) begin
            set_in(1, 3, 1, 0, 0, 4, 0, 0, 0, 0);
            cyc();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        for (int i = 0; i < 70; i++) begin
            set_in(1, 3, 1, 0, 0, 4, 0, 0, 0, 0);
            checks++; if (stall_o !== 1'b1 || timeout_o !== (i >= TO)) begin errors++; $display("FAIL to_run c%0d: got stall %b timeout %b exp 1 %b", i, stall_o, timeout_o, (i >= TO)); end
            cyc();
        end
        set_in(1, 3, 1, 0, 0, 4, 0, 0, 0, 0);
        checks++; if (cnt_o !== 8'd110 || timeout_o !== 1'b1) begin errors++; $display("FAIL to_sticky: got cnt %0d to %b exp 110 1", cnt_o, timeout_o); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy_o !== 32'h0 || timeout_o !== 1'b0 || stall_o !== 1'b0 || cnt_o !== '0) begin errors++; $display("FAIL to_async_rst: got busy %h to %b stall %b cnt %0d exp 0 0 0 0", busy_o, timeout_o, stall_o, cnt_o); end
        do_reset();
    endtask

    task automatic test_saturate();
        do_reset();
        set_in(1, 0, 0, 0, 0, 4, 1, 0, 0, 0);
        cyc();
        for (int i = 0; i < 260; i++) begin
            set_in(1, 0, 0, 4, 1, 5, 0, 0, 0, 0);
            cyc();
        end
        checks++; if (cnt_o !== 8'd255) begin errors++; $display("FAIL sat_cnt: got %0d exp 255", cnt_o); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom_range(0, 9) < 8), 5'($urandom_range(0, 7)), ($urandom_range(0, 1) == 1),
                   5'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
                   ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) < 2), 5'($urandom_range(0, 7)),
                   ($urandom_range(0, 19) == 0));
            checks++; if ({issue_o, stall_o, flush_o} !== {m_issue, m_stall, m_flush}) begin errors++; $display("FAIL rand_comb c%0d: got i/s/f %b exp %b", i, {issue_o, stall_o, flush_o}, {m_issue, m_stall, m_flush}); end
            cyc();
            checks++; if (busy_o !== m_busy || cnt_o !== CW'(m_total) || timeout_o !== m_timeout) begin errors++; $display("FAIL rand_state c%0d: got busy %h cnt %0d to %b exp %h %0d %b", i, busy_o, cnt_o, timeout_o, m_busy, m_total, m_timeout); end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_x0();
        test_redirect_stall();
        test_flush_extend();
        test_set_clear();
        test_timeout();
        test_saturate();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
